// File: rtl/mem_port_unit.sv
// Request/response memory port for the multicycle core: wait states, bus timeout,
// byte-lane steering, misalignment detection and load sign/zero extension.
//
// state | meaning
// IDLE  | ready for a core request; misaligned requests answer directly
// BUS   | bus request held stable until mem_ready or timeout
// RESP  | one-cycle response pulse, then back to IDLE
module mem_port_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_err,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int NB = DATA_W / 8;
    localparam int OW = $clog2(NB);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RESP
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [OW-1:0] req_off;
    logic          misaligned;
    logic          bus_timeout;
    logic [CW-1:0] wait_cnt;

    logic          lat_write;
    logic [1:0]    lat_size;
    logic          lat_unsigned;
    logic [OW-1:0] lat_off;

    function automatic logic [NB-1:0] lane_mask(input logic [1:0] size, input logic [OW-1:0] off);
        logic [NB-1:0] m;
        case (size)
            2'd0:    m = NB'(1);
            2'd1:    m = NB'(3);
            2'd2:    m = NB'(15);
            default: m = '1;
        endcase
        return m << off;
    endfunction

    function automatic logic [DATA_W-1:0] lane_data(input logic [1:0] size, input logic [DATA_W-1:0] wdata);
        logic [DATA_W-1:0] d;
        case (size)
            2'd0:    d = {NB{wdata[7:0]}};
            2'd1:    d = {(NB/2){wdata[15:0]}};
            2'd2:    d = {(NB/4){wdata[31:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    // Keep the accessed bytes; the sign fill covers everything above them.
    function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] sh,
                                                      input logic [1:0]        size,
                                                      input logic              uns);
        logic [DATA_W-1:0] keep;
        logic              fill;
        case (size)
            2'd0:    begin keep = DATA_W'(8'hFF);          fill = sh[7];  end
            2'd1:    begin keep = DATA_W'(16'hFFFF);       fill = sh[15]; end
            2'd2:    begin keep = DATA_W'(32'hFFFF_FFFF);  fill = sh[31]; end
            default: begin keep = '1;                      fill = 1'b0;   end
        endcase
        return (sh & keep) | ((!uns && fill) ? ~keep : '0);
    endfunction

    assign req_off   = req_addr[OW-1:0];
    assign req_ready = (state == S_IDLE) && !reset;

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd1:    misaligned = req_off[0];
            2'd2:    misaligned = |req_off[1:0];
            2'd3:    misaligned = (DATA_W != 64) || (req_off != '0);
            default: misaligned = 1'b0;
        endcase
    end

    // wait_cnt counts down from TIMEOUT; terminal count on the last allowed BUS cycle.
    assign bus_timeout = (state == S_BUS) && !mem_ready && (TIMEOUT != 0) && (wait_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    state_next = misaligned ? S_RESP : S_BUS;
                end
            end
            S_BUS: begin
                if (mem_ready || bus_timeout) begin
                    state_next = S_RESP;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid    <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_be       <= '0;
            mem_wdata    <= '0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= 2'b00;
            wait_cnt     <= '0;
            lat_write    <= 1'b0;
            lat_size     <= 2'd0;
            lat_unsigned <= 1'b0;
            lat_off      <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 2'b00;
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        lat_write    <= req_write;
                        lat_size     <= req_size;
                        lat_unsigned <= req_unsigned;
                        lat_off      <= req_off;
                        if (misaligned) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 2'b01;
                        end else begin
                            mem_valid <= 1'b1;
                            mem_we    <= req_write;
                            mem_addr  <= req_addr & ~ADDR_W'(NB - 1);
                            mem_be    <= lane_mask(req_size, req_off);
                            mem_wdata <= lane_data(req_size, req_wdata);
                            wait_cnt  <= CW'(TIMEOUT);
                        end
                    end
                end
                S_BUS: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= lat_write ? '0
                                   : load_extend(mem_rdata >> {lat_off, 3'b000}, lat_size, lat_unsigned);
                    end else if (bus_timeout) begin
                        mem_valid <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 2'b10;
                    end else if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_unit.sv
// Bench for mem_port_unit: a 32-bit instance with TIMEOUT=4 and a 64-bit instance
// with the timeout disabled, checked against a byte-level reference model.
module tb_mem_port_unit;

    localparam int TO32 = 4;
    localparam int TO64 = 0;

    logic        clk = 1'b0;
    logic        rst32, rst64;
    logic        rv32, rv64;
    logic        req_write, req_unsigned, mem_ready;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [63:0] req_wdata, mem_rdata;

    logic        req_ready32, rsp_valid32, mem_valid32, mem_we32;
    logic [1:0]  rsp_err32;
    logic [31:0] rsp_rdata32, mem_addr32, mem_wdata32;
    logic [3:0]  mem_be32;

    logic        req_ready64, rsp_valid64, mem_valid64, mem_we64;
    logic [1:0]  rsp_err64;
    logic [63:0] rsp_rdata64, mem_wdata64;
    logic [31:0] mem_addr64;
    logic [7:0]  mem_be64;

    logic        sel;
    logic        o_rr, o_rv, o_mv, o_we;
    logic [1:0]  o_err;
    logic [63:0] o_rd, o_wd;
    logic [31:0] o_addr;
    logic [7:0]  o_be;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_acc = 0;
    int prev_acc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO32)) u32 (
        .clk(clk), .reset(rst32), .req_valid(rv32), .req_ready(req_ready32),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .rsp_valid(rsp_valid32), .rsp_rdata(rsp_rdata32), .rsp_err(rsp_err32),
        .mem_valid(mem_valid32), .mem_ready(mem_ready), .mem_we(mem_we32),
        .mem_addr(mem_addr32), .mem_be(mem_be32), .mem_wdata(mem_wdata32),
        .mem_rdata(mem_rdata[31:0])
    );

    mem_port_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(TO64)) u64 (
        .clk(clk), .reset(rst64), .req_valid(rv64), .req_ready(req_ready64),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid64), .rsp_rdata(rsp_rdata64), .rsp_err(rsp_err64),
        .mem_valid(mem_valid64), .mem_ready(mem_ready), .mem_we(mem_we64),
        .mem_addr(mem_addr64), .mem_be(mem_be64), .mem_wdata(mem_wdata64),
        .mem_rdata(mem_rdata)
    );

    always_comb begin
        if (sel) begin
            o_rr = req_ready64;  o_rv = rsp_valid64;  o_mv = mem_valid64;  o_we = mem_we64;
            o_err = rsp_err64;   o_rd = rsp_rdata64;  o_wd = mem_wdata64;
            o_addr = mem_addr64; o_be = mem_be64;
        end else begin
            o_rr = req_ready32;  o_rv = rsp_valid32;  o_mv = mem_valid32;  o_we = mem_we32;
            o_err = rsp_err32;   o_rd = {32'b0, rsp_rdata32};  o_wd = {32'b0, mem_wdata32};
            o_addr = mem_addr32; o_be = {4'b0, mem_be32};
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_be(input int sz, input int off);
        return ((64'd1 << sz) - 64'd1) << off;
    endfunction

    function automatic logic [63:0] exp_wdata(input int nb, input int sz, input logic [63:0] wd);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < nb; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [63:0] exp_load(input int nb, input int sz, input int off,
                                             input logic uns, input logic [63:0] rd);
        logic [63:0] v, mask;
        v = (nb == 4) ? (rd & 64'hFFFF_FFFF) : rd;
        v = v >> (8 * off);
        mask = (sz == 8) ? '1 : ((64'd1 << (8 * sz)) - 64'd1);
        v = v & mask;
        if (!uns && v[8*sz-1]) v = v | ~mask;
        if (nb == 4) v = v & 64'hFFFF_FFFF;
        return v;
    endfunction

    // One transaction from accept to the cycle after the response; called and
    // returning on a falling edge.
    task automatic run(input logic s, input logic wr, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                       input int waits);
        int nb, sz, off, tmo, c_rsp;
        logic mis;
        logic [1:0] e_err;
        logic [63:0] e_rd;
        nb  = s ? 8 : 4;
        sz  = 1 << size;
        off = int'(addr[2:0]) % nb;
        tmo = s ? TO64 : TO32;
        mis = ((off % sz) != 0) || (size == 2'd3 && nb == 4);
        if (mis) begin
            c_rsp = 0; e_err = 2'b01;
        end else if (tmo != 0 && waits > tmo) begin
            c_rsp = tmo + 1; e_err = 2'b10;
        end else begin
            c_rsp = waits + 1; e_err = 2'b00;
        end
        e_rd = (wr || e_err != 2'b00) ? 64'd0 : exp_load(nb, sz, off, uns, rd);

        sel = s; req_write = wr; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wd; mem_rdata = rd; mem_ready = 1'b0;
        if (s) rv64 = 1'b1; else rv32 = 1'b1;
        #1;
        check("req_ready_idle", 64'(o_rr), 64'd1);
        prev_acc = last_acc;
        last_acc = cyc;
        @(posedge clk);
        @(negedge clk);
        rv32 = 1'b0; rv64 = 1'b0;
        for (int c = 0; c <= c_rsp; c++) begin
            if (c == c_rsp) begin
                check("rsp_valid", 64'(o_rv), 64'd1);
                check("rsp_err", 64'(o_err), 64'(e_err));
                check("rsp_rdata", o_rd, e_rd);
                check("mem_valid_drop", 64'(o_mv), 64'd0);
            end else begin
                check("rsp_valid_early", 64'(o_rv), 64'd0);
                check("mem_valid_bus", 64'(o_mv), 64'(!mis));
                if (!mis) begin
                    check("mem_addr", 64'(o_addr), 64'(addr & ~32'(nb - 1)));
                    check("mem_be", 64'(o_be), exp_be(sz, off));
                    check("mem_we", 64'(o_we), 64'(wr));
                    if (wr) check("mem_wdata", o_wd, exp_wdata(nb, sz, wd));
                end
                mem_ready = !mis && (c == waits);
                @(posedge clk);
                @(negedge clk);
            end
        end
        mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rsp_pulse_end", 64'(o_rv), 64'd0);
        check("req_ready_back", 64'(o_rr), 64'd1);
    endtask

    initial begin
        rst32 = 1'b1; rst64 = 1'b1; rv32 = 1'b0; rv64 = 1'b0; sel = 1'b0;
        req_write = 1'b0; req_unsigned = 1'b0; req_size = 2'd0; req_addr = '0;
        req_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready32", 64'(req_ready32), 64'd0);
        check("rst_req_ready64", 64'(req_ready64), 64'd0);
        check("rst_mem_valid32", 64'(mem_valid32), 64'd0);
        check("rst_mem_be32", 64'(mem_be32), 64'd0);
        check("rst_mem_addr64", 64'(mem_addr64), 64'd0);
        check("rst_mem_wdata64", mem_wdata64, 64'd0);
        check("rst_mem_we64", 64'(mem_we64), 64'd0);
        check("rst_rsp_valid64", 64'(rsp_valid64), 64'd0);
        check("rst_rsp_rdata32", 64'(rsp_rdata32), 64'd0);
        check("rst_rsp_err32", 64'(rsp_err32), 64'd0);
        rst32 = 1'b0; rst64 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_ready64", 64'(req_ready64), 64'd1);

        run(0, 0, 2'd2, 0, 32'h100, 64'd0, 64'hDEAD_BEEF, 0);
        run(0, 0, 2'd0, 0, 32'h103, 64'd0, 64'h80FF_1234, 0);
        check("b2b_gap", 64'(last_acc - prev_acc), 64'd3);
        run(0, 0, 2'd0, 1, 32'h103, 64'd0, 64'h80FF_1234, 0);
        run(0, 1, 2'd1, 0, 32'h202, 64'h0000_ABCD, 64'd0, 3);
        run(0, 0, 2'd2, 0, 32'h101, 64'd0, 64'h1111_2222, 0);
        run(0, 0, 2'd2, 0, 32'h300, 64'd0, 64'h1234_5678, 10);
        run(0, 0, 2'd2, 1, 32'h304, 64'd0, 64'h8765_4321, TO32);
        run(0, 0, 2'd3, 0, 32'h008, 64'd0, 64'h1, 0);
        run(1, 0, 2'd3, 0, 32'h008, 64'd0, 64'h0123_4567_89AB_CDEF, 0);
        run(1, 0, 2'd2, 0, 32'h00C, 64'd0, 64'h8000_0000_0000_0000, 2);
        run(1, 1, 2'd0, 0, 32'h015, 64'h5A, 64'd0, 1);

        for (int i = 0; i < 60; i++) begin
            run(1'($urandom), 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                32'($urandom_range(0, 4095)), {$urandom, $urandom}, {$urandom, $urandom},
                $urandom_range(0, 6));
        end

        // Timeout disabled: the bus request stays up until reset abandons it.
        sel = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h40; mem_ready = 1'b0; rv64 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rv64 = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            check("hold_mem_valid", 64'(mem_valid64), 64'd1);
            check("hold_no_rsp", 64'(rsp_valid64), 64'd0);
            @(posedge clk);
            @(negedge clk);
        end
        rst64 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_mem_valid", 64'(mem_valid64), 64'd0);
        check("abort_rsp_valid", 64'(rsp_valid64), 64'd0);
        check("abort_mem_be", 64'(mem_be64), 64'd0);
        check("abort_req_ready", 64'(req_ready64), 64'd0);
        rst64 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_ready_back", 64'(req_ready64), 64'd1);
        for (int c = 0; c < 5; c++) begin
            check("abort_no_rsp", 64'(rsp_valid64), 64'd0);
            @(posedge clk);
            @(negedge clk);
        end
        run(1, 0, 2'd1, 0, 32'h046, 64'd0, 64'hFEDC_BA98_7654_3210, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_unit.md
# mem_port_unit

Parametrised memory-port unit for the multicycle RISC-V core. It replaces direct single-cycle `address`/`data_in`/`data_out`/`we` wiring with a request/response handshake. It adds wait-state tolerance through `mem_ready`, a bus timeout, byte-lane steering with byte enables, misalignment detection, and load sign/zero extension. It sits between the control unit / datapath registers and the external memory bus, serving both instruction fetches and loads/stores.

## Interface
- `DATA_W`, 32: bus and register width; must be 32 or 64.
- `ADDR_W`, 32: byte address width.
- `TIMEOUT`, 255: cycles to wait for `mem_ready` before a bus error; 0 disables the timeout.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  core request present.
- `req_ready`  out  1  unit can accept; `req_ready = (state==IDLE) & ~reset`.
- `req_write`  in  1  1 = store, 0 = load/fetch.
- `req_size`  in  2  0 byte, 1 half, 2 word, 3 dword; 3 is legal only when `DATA_W=64`, otherwise it reports a misaligned error.
- `req_unsigned`  in  1  zero-extend the load (LBU/LHU/LWU); 0 = sign-extend.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  DATA_W  store data, right-aligned.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  DATA_W  extended load data; 0 for stores and errors.
- `rsp_err`  out  2  00 ok, 01 misaligned/illegal size, 10 timeout.
- `mem_valid`  out  1  bus request.
- `mem_ready`  in  1  bus completes the access this cycle.
- `mem_we`  out  1  bus write.
- `mem_addr`  out  ADDR_W  `req_addr` with the low log2(DATA_W/8) bits cleared.
- `mem_be`  out  DATA_W/8  byte enables.
- `mem_wdata`  out  DATA_W  lane-steered store data.
- `mem_rdata`  in  DATA_W  bus read data.

## Operation
- Derived quantities:
  - `NB = DATA_W/8`
  - `off = req_addr[log2(NB)-1:0]`
  - `sz = 1<<req_size` bytes
- Misaligned when `off % sz != 0`, or when `req_size=3` with `DATA_W=32`.
- FSM states are IDLE, BUS, RESP.
  - **IDLE:** on `req_valid & req_ready`, latch all `req_*` fields.
    - If the request is misaligned, go to RESP with `rsp_err=01`; no bus cycle is issued.
    - Otherwise go to BUS and clear the wait counter.
  - **BUS:** `mem_valid=1`.
    - `mem_addr`, `mem_we`, `mem_be` and `mem_wdata` are held stable from the latched fields until `mem_ready`.
    - On `mem_ready`, capture `mem_rdata` and go to RESP with `rsp_err=00`.
    - Otherwise increment the counter. When `TIMEOUT != 0` and the counter equals `TIMEOUT`, go to RESP with `rsp_err=10`.
  - **RESP:** `rsp_valid=1` for exactly one cycle, then return to IDLE.
- Byte enables: `mem_be = ((1<<sz)-1) << off`.
- Store data: `req_wdata[8*sz-1:0]` is replicated across every `sz`-byte lane group of `mem_wdata`.
- Load data:
  - Shift `mem_rdata` right by `8*off`.
  - Keep `8*sz` bits.
  - Sign-extend from bit `8*sz-1` unless `req_unsigned`; then zero-extend.
  - The result is `DATA_W` wide.
- `rsp_rdata` is 0 for stores, misaligned requests and timeouts.
- Single outstanding transaction; no request is accepted in BUS or RESP.
- A `mem_ready` seen outside BUS is ignored.

## Timing
- Reset values:
  - state IDLE
  - `mem_valid=0`, `mem_we=0`, `mem_be=0`, `mem_addr=0`, `mem_wdata=0`
  - `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=00`
  - `req_ready=0` while `reset` is high
- All outputs except `req_ready` are registered.
- Cycle 0 is the edge that accepts the request.
  - `mem_valid` rises after cycle 0.
  - If `mem_ready` is high in the first BUS cycle, `rsp_valid` is asserted in the cycle after it.
  - Minimum accept-to-response latency is 2 cycles; each wait state adds 1.
- Misaligned request: `rsp_valid` is asserted the cycle after accept, giving 1-cycle latency.
- Timeout: `mem_valid` is held for `TIMEOUT+1` cycles, drops together with the RESP entry, and `rsp_err=10`.
- `req_ready` returns to 1 the cycle after the `rsp_valid` pulse.
- Back-to-back requests: 3 cycles per zero-wait access.
- `mem_ready` arriving in the same cycle the timeout triggers counts as success, `rsp_err=00`.
- Reset asserted mid-transaction:
  - abandon the access
  - all outputs return to reset values on the next edge
  - no `rsp_valid` is ever issued for the abandoned request

## Test plan
- **Word load:** `DATA_W=32`, load word at `0x100`, `mem_rdata=0xDEADBEEF`, zero wait. Expect `mem_be=1111`, `mem_addr=0x100`, `rsp_valid` 2 cycles after accept, `rsp_rdata=0xDEADBEEF`, `rsp_err=00`.
- **Byte load, signed and unsigned:** load byte at `0x103`, `mem_rdata=0x80FF1234`. Signed gives `0xFFFFFF80`; unsigned gives `0x00000080`; `mem_be=1000` in both cases.
- **Half store:** store half at `0x202`, `req_wdata=0x0000ABCD`. Expect `mem_be=1100`, `mem_wdata=0xABCDABCD`, `mem_we=1`. Then assert `mem_ready` after 3 wait states; expect `rsp_valid` 5 cycles after accept.
- **Misaligned word:** load word at `0x101`. Expect `rsp_err=01` and `rsp_valid` 1 cycle after accept; `mem_valid` is never asserted.
- **Timeout:** `TIMEOUT=4`, hold `mem_ready=0`. Expect `mem_valid` high for 5 cycles, then `rsp_err=10` and `rsp_rdata=0`. With `TIMEOUT=0`, `mem_valid` is held for 1000 cycles with no response.
- **64-bit dword and reset abort:** `DATA_W=64`, dword load at `0x8` returns `mem_rdata` unchanged with `mem_be=0xFF`. Then pulse `reset` during BUS; expect `mem_valid=0` the next cycle, no `rsp_valid`, and `req_ready=1` after reset drops.
